// File: rtl/window_allocator_pkg.sv
// Shared widths, FSM encoding and payload tag for the window allocator slot.
package window_allocator_pkg;

  localparam int unsigned COORD_W = 8;
  localparam int unsigned DIFF_W  = COORD_W + 1;
  localparam int unsigned HALF_W  = 2;
  localparam int unsigned DEPTH_W = 9;
  localparam int unsigned OFF_W   = 3;
  // 49 * 511 = 25039 needs 15 bits
  localparam int unsigned CNT_W   = 15;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_DRAIN   = 2'd2
  } state_e;

  typedef struct packed {
    logic [OFF_W-1:0] dx;
    logic [OFF_W-1:0] dy;
    logic             last;
  } win_tag_t;

  // Words in a (2h+1)x(2h+1)xdepth window
  function automatic logic [CNT_W-1:0] window_total(input logic [HALF_W-1:0]  h,
                                                    input logic [DEPTH_W-1:0] depth);
    logic [OFF_W-1:0] side;
    logic [5:0]       area;
    side = {h, 1'b1};
    area = 6'(side) * 6'(side);
    return CNT_W'(area) * CNT_W'(depth);
  endfunction

endpackage

// File: rtl/window_allocator_if.sv
// Positioner, issue-bus snoop and output-stream signals of one allocator slot.
interface window_allocator_if #(parameter int unsigned DATA_W = 8);
  import window_allocator_pkg::*;

  logic [HALF_W-1:0]  cfg_halfsize;
  logic [DEPTH_W-1:0] cfg_depth;
  logic [COORD_W-1:0] pos_x;
  logic [COORD_W-1:0] pos_y;
  logic               pos_select;
  logic [COORD_W-1:0] issue_x;
  logic [COORD_W-1:0] issue_y;
  logic [DATA_W-1:0]  issue_data;
  logic               issue_en;
  logic               issue_block;
  logic [DATA_W-1:0]  out_data;
  logic [OFF_W-1:0]   out_dx;
  logic [OFF_W-1:0]   out_dy;
  logic               out_last;
  logic               out_valid;
  logic               out_ready;
  logic               busy;
  logic               done;
  logic               err;

  modport master (
    output cfg_halfsize, cfg_depth, pos_x, pos_y, pos_select,
    output issue_x, issue_y, issue_data, issue_en, out_ready,
    input  issue_block, out_data, out_dx, out_dy, out_last, out_valid,
    input  busy, done, err
  );

  modport slave (
    input  cfg_halfsize, cfg_depth, pos_x, pos_y, pos_select,
    input  issue_x, issue_y, issue_data, issue_en, out_ready,
    output issue_block, out_data, out_dx, out_dy, out_last, out_valid,
    output busy, done, err
  );

endinterface

// File: rtl/alloc_fifo.sv
// Show-ahead synchronous FIFO; a push into a full FIFO is dropped unless a pop frees a slot.
module alloc_fifo #(
  parameter int unsigned WIDTH = 15,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_pop;
  logic             do_push;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/window_allocator.sv
// One allocator slot: arms on pos_select, keeps issue-bus words inside its window,
// buffers them and streams them out with window-relative offsets.
module window_allocator
  import window_allocator_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  window_allocator_if.slave   bus
);

  localparam int unsigned TAG_W   = $bits(win_tag_t);
  localparam int unsigned ENTRY_W = DATA_W + TAG_W;
  localparam int unsigned CW      = $clog2(FIFO_DEPTH) + 1;

  state_e             state;
  state_e             state_next;
  logic [COORD_W-1:0] px_q;
  logic [COORD_W-1:0] py_q;
  logic [HALF_W-1:0]  h_q;
  logic [CNT_W-1:0]   total_q;
  logic [CNT_W-1:0]   acc_q;
  logic               done_q;
  logic               busy_q;
  logic               block_q;
  logic               err_q;

  logic [DIFF_W-1:0]  dx_c;
  logic [DIFF_W-1:0]  dy_c;
  logic [OFF_W-1:0]   span_c;
  logic               keep_c;
  logic               last_c;
  logic               arm_c;
  logic               pop_c;
  logic               push_ok_c;
  logic               fin_c;
  logic [CNT_W-1:0]   total_arm_c;
  logic [CW-1:0]      fifo_cnt_next;
  win_tag_t           tag_c;
  win_tag_t           head_tag;

  logic [ENTRY_W-1:0] fifo_dout;
  logic               fifo_empty;
  logic               fifo_full;
  logic [CW-1:0]      fifo_cnt;

  // Window compare: offsets below the window wrap to large 9-bit values and fail the test
  assign span_c = {h_q, 1'b0};
  assign dx_c   = {1'b0, bus.issue_x} - {1'b0, px_q} + DIFF_W'(h_q);
  assign dy_c   = {1'b0, bus.issue_y} - {1'b0, py_q} + DIFF_W'(h_q);
  assign keep_c = (state == S_COLLECT) && bus.issue_en &&
                  (dx_c <= DIFF_W'(span_c)) && (dy_c <= DIFF_W'(span_c));
  assign last_c = ((acc_q + CNT_W'(1)) == total_q);
  assign arm_c  = (state == S_IDLE) && bus.pos_select;
  assign total_arm_c = window_total(bus.cfg_halfsize, bus.cfg_depth);

  assign tag_c = '{dx: dx_c[OFF_W-1:0], dy: dy_c[OFF_W-1:0], last: last_c};

  assign pop_c         = !fifo_empty && bus.out_ready;
  assign push_ok_c     = keep_c && (!fifo_full || pop_c);
  assign fifo_cnt_next = fifo_cnt + CW'(push_ok_c) - CW'(pop_c);

  alloc_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (keep_c),
    .pop   (pop_c),
    .din   ({bus.issue_data, tag_c}),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // DRAIN ends when the buffer empties, so a dropped last word still closes the window
  always_comb begin
    state_next = state;
    fin_c      = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.pos_select) state_next = (total_arm_c == '0) ? S_DRAIN : S_COLLECT;
      end
      S_COLLECT: begin
        if (keep_c && last_c) state_next = S_DRAIN;
      end
      S_DRAIN: begin
        if ((fifo_cnt == '0) || (pop_c && (fifo_cnt == CW'(1)))) begin
          state_next = S_IDLE;
          fin_c      = 1'b1;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      px_q    <= '0;
      py_q    <= '0;
      h_q     <= '0;
      total_q <= '0;
      acc_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      block_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      if (arm_c) begin
        px_q    <= bus.pos_x;
        py_q    <= bus.pos_y;
        h_q     <= bus.cfg_halfsize;
        total_q <= total_arm_c;
        acc_q   <= '0;
      end else if (keep_c) begin
        acc_q <= acc_q + CNT_W'(1);
      end
      if ((bus.pos_select && (state != S_IDLE)) || (keep_c && fifo_full && !pop_c))
        err_q <= 1'b1;
      done_q  <= fin_c;
      busy_q  <= (state_next != S_IDLE);
      // Two entries of headroom absorb Issue's one-cycle reaction
      block_q <= (state_next == S_COLLECT) && (fifo_cnt_next >= CW'(FIFO_DEPTH - 2));
    end
  end

  assign head_tag        = win_tag_t'(fifo_dout[TAG_W-1:0]);
  assign bus.out_data    = fifo_dout[ENTRY_W-1:TAG_W];
  assign bus.out_dx      = head_tag.dx;
  assign bus.out_dy      = head_tag.dy;
  assign bus.out_last    = head_tag.last;
  assign bus.out_valid   = !fifo_empty;
  assign bus.issue_block = block_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.err         = err_q;

endmodule
